// File: rtl/warehouse_pkg.sv
// Shared types and constants for the warehouse command receiver: FSM states,
// error codes, frame header and coordinate widths.
package warehouse_pkg;

  localparam logic [7:0] HDR_BYTE = 8'hAA;
  localparam int         MAX_NOB  = 24;
  localparam int         XW       = 9;
  localparam int         YW       = 8;

  localparam logic [1:0] ERR_CHK   = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_RDY   = 2'd2;
  localparam logic [1:0] ERR_GAP   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_NOB,
    ST_GET_CHK,
    ST_REQ,
    ST_WAIT_RDY,
    ST_DONE,
    ST_HOLD,
    ST_ERR
  } state_e;

  function automatic logic nob_in_range(input logic [7:0] nob);
    return (nob != 8'd0) && (nob <= 8'(MAX_NOB));
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, LSB first.
// Bytes with a low stop bit are dropped and the receiver waits for line idle.
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int             CPB  = CLK_FREQ / BAUD;
  localparam int             CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0]  HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CPB - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  rx_state_e     st_q, st_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          rx_s;

  assign rx_s     = sync_q[1];
  assign rx_data  = data_q;
  assign rx_valid = valid_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q  <= 2'b11;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) st_d = RX_START;
      end
      RX_START: begin
        // Glitches shorter than half a bit fall back to idle.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            st_d    = RX_IDLE;
          end else begin
            st_d = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s) st_d = RX_IDLE;
      end
      default: st_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/warehouse_cmd_rx.sv
// Frame FSM: receives HDR/NOB/CHK over UART, requests a coordinate lookup
// and latches the returned x/y for the arm motion controller.
module warehouse_cmd_rx
  import warehouse_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int RDY_TIMEOUT = 64,
  parameter int GAP_TIMEOUT = CLK_FREQ / 100
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          uart_rx,
  input  logic          ready_flag,
  input  logic [XW-1:0] x_warehouse,
  input  logic [YW-1:0] y_warehouse,
  output logic [5:0]    warehouse_nob,
  output logic          en_flag,
  output logic [XW-1:0] x_target,
  output logic [YW-1:0] y_target,
  output logic          target_valid,
  output logic          system_start,
  output logic          busy,
  output logic          err_pulse,
  output logic [1:0]    err_code,
  output state_e        state_dbg
);

  localparam int            TMAX     = (GAP_TIMEOUT > RDY_TIMEOUT) ? GAP_TIMEOUT : RDY_TIMEOUT;
  localparam int            TW       = $clog2(TMAX + 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TIMEOUT - 1);
  localparam logic [TW-1:0] RDY_LAST = TW'(RDY_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(3);

  logic [7:0] rx_data;
  logic       rx_valid;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx       (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  state_e        state_q, state_d;
  logic [7:0]    nob_q, nob_d;
  logic [5:0]    wnob_q, wnob_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    code_q, code_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rdy_prev_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      nob_q      <= '0;
      wnob_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      code_q     <= '0;
      tmr_q      <= '0;
      rdy_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nob_q      <= nob_d;
      wnob_q     <= wnob_d;
      x_q        <= x_d;
      y_q        <= y_d;
      code_q     <= code_d;
      tmr_q      <= tmr_d;
      rdy_prev_q <= ready_flag;
    end
  end

  // One shared timer: gap in GET_NOB/GET_CHK, ready wait from REQ, settle in HOLD.
  always_comb begin
    state_d = state_q;
    nob_d   = nob_q;
    wnob_d  = wnob_q;
    x_d     = x_q;
    y_d     = y_q;
    code_d  = code_q;
    tmr_d   = tmr_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (rx_valid && rx_data == HDR_BYTE) state_d = ST_GET_NOB;
      end
      ST_GET_NOB: begin
        if (rx_valid) begin
          nob_d   = rx_data;
          tmr_d   = '0;
          state_d = ST_GET_CHK;
        end else if (tmr_q == GAP_LAST) begin
          code_d  = ERR_GAP;
          state_d = ST_ERR;
        end
      end
      ST_GET_CHK: begin
        if (rx_valid) begin
          tmr_d = '0;
          if (rx_data != (HDR_BYTE ^ nob_q)) begin
            code_d  = ERR_CHK;
            state_d = ST_ERR;
          end else if (!nob_in_range(nob_q)) begin
            code_d  = ERR_RANGE;
            state_d = ST_ERR;
          end else begin
            wnob_d  = nob_q[5:0];
            state_d = ST_REQ;
          end
        end else if (tmr_q == GAP_LAST) begin
          code_d  = ERR_GAP;
          state_d = ST_ERR;
        end
      end
      ST_REQ: state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (ready_flag && !rdy_prev_q) begin
          x_d     = x_warehouse;
          y_d     = y_warehouse;
          state_d = ST_DONE;
        end else if (tmr_q == RDY_LAST) begin
          code_d  = ERR_RDY;
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        tmr_d   = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: if (tmr_q == HOLD_LAST) state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign warehouse_nob = wnob_q;
  assign en_flag       = (state_q == ST_REQ);
  assign x_target      = x_q;
  assign y_target      = y_q;
  assign target_valid  = (state_q == ST_DONE);
  assign system_start  = (state_q == ST_DONE);
  assign busy          = (state_q == ST_GET_NOB) || (state_q == ST_GET_CHK) ||
                         (state_q == ST_REQ) || (state_q == ST_WAIT_RDY);
  assign err_pulse     = (state_q == ST_ERR);
  assign err_code      = code_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_warehouse_cmd_rx.sv
// Directed bench for warehouse_cmd_rx: UART frame driver, lookup responder
// model, pulse monitors and immediate-assertion checks.
module tb_warehouse_cmd_rx;
  import warehouse_pkg::*;

  localparam int CLK_FREQ = 800_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int GAP      = CLK_FREQ / 100;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       uart_rx    = 1'b1;
  logic       ready_flag = 1'b0;
  logic [8:0] x_wh       = '0;
  logic [7:0] y_wh       = '0;
  logic [5:0] warehouse_nob;
  logic       en_flag, target_valid, system_start, busy, err_pulse;
  logic [8:0] x_target;
  logic [7:0] y_target;
  logic [1:0] err_code;
  state_e     state_dbg;

  warehouse_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .RDY_TIMEOUT(64)) dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .uart_rx       (uart_rx),
    .ready_flag    (ready_flag),
    .x_warehouse   (x_wh),
    .y_warehouse   (y_wh),
    .warehouse_nob (warehouse_nob),
    .en_flag       (en_flag),
    .x_target      (x_target),
    .y_target      (y_target),
    .target_valid  (target_valid),
    .system_start  (system_start),
    .busy          (busy),
    .err_pulse     (err_pulse),
    .err_code      (err_code),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // lookup model: answers 10 cycles after en_flag, ready high for 2 cycles
  logic       model_on = 1'b0;
  logic [8:0] model_x  = '0;
  logic [7:0] model_y  = '0;
  always begin
    @(negedge clk);
    if (en_flag && model_on) begin
      repeat (10) @(posedge clk);
      #1;
      ready_flag = 1'b1;
      x_wh       = model_x;
      y_wh       = model_y;
      repeat (2) @(posedge clk);
      #1;
      ready_flag = 1'b0;
    end
  end

  // pulse monitors
  int cyc = 0, en_cnt = 0, tv_cnt = 0, ss_cnt = 0, err_cnt = 0, coinc_bad = 0;
  int en_cyc = 0, err_cyc = 0;
  logic [5:0] last_nob = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (en_flag) begin
      en_cnt++;
      en_cyc   = cyc;
      last_nob = warehouse_nob;
    end
    if (target_valid) tv_cnt++;
    if (system_start) ss_cnt++;
    if (target_valid != system_start) coinc_bad++;
    if (err_pulse) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(CPB);
    end
    uart_rx = stop_bit;
    wait_cycles(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] n, input logic [7:0] c);
    send_byte(h, 1'b1);
    send_byte(n, 1'b1);
    send_byte(c, 1'b1);
  endtask

  int en0, tv0, ss0, err0;
  task automatic snap();
    en0  = en_cnt;
    tv0  = tv_cnt;
    ss0  = ss_cnt;
    err0 = err_cnt;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    check("rst_nob", 32'(warehouse_nob), 0);
    check("rst_en", 32'(en_flag), 0);
    check("rst_x", 32'(x_target), 0);
    check("rst_y", 32'(y_target), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_code", 32'(err_code), 0);

    // 1: good frame, lookup answers (210,150)
    model_on = 1'b1; model_x = 9'd210; model_y = 8'd150;
    snap();
    send_byte(8'hAA, 1'b1);
    wait_cycles(2);
    check("t1_busy_after_hdr", 32'(busy), 1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hAF, 1'b1);
    wait_cycles(150);
    check("t1_en_count", 32'(en_cnt - en0), 1);
    check("t1_nob_at_en", 32'(last_nob), 5);
    check("t1_nob_held", 32'(warehouse_nob), 5);
    check("t1_x", 32'(x_target), 210);
    check("t1_y", 32'(y_target), 150);
    check("t1_tv_count", 32'(tv_cnt - tv0), 1);
    check("t1_ss_count", 32'(ss_cnt - ss0), 1);
    check("t1_no_err", 32'(err_cnt - err0), 0);
    check("t1_busy_low", 32'(busy), 0);

    // 2: checksum error
    snap();
    send_frame(8'hAA, 8'h05, 8'h00);
    wait_cycles(40);
    check("t2_err_count", 32'(err_cnt - err0), 1);
    check("t2_err_code", 32'(err_code), 0);
    check("t2_no_en", 32'(en_cnt - en0), 0);
    check("t2_x_kept", 32'(x_target), 210);

    // 3: range errors (0 and 25)
    snap();
    send_frame(8'hAA, 8'h00, 8'hAA);
    wait_cycles(40);
    check("t3a_err_count", 32'(err_cnt - err0), 1);
    check("t3a_err_code", 32'(err_code), 1);
    snap();
    send_frame(8'hAA, 8'h19, 8'hB3);
    wait_cycles(40);
    check("t3b_err_count", 32'(err_cnt - err0), 1);
    check("t3b_err_code", 32'(err_code), 1);
    check("t3b_no_en", 32'(en_cnt - en0), 0);

    // 4: NOB=24 accepted, lookup silent -> timeout after 64 cycles
    model_on = 1'b0;
    snap();
    send_frame(8'hAA, 8'h18, 8'hB2);
    wait_cycles(150);
    check("t4_en_count", 32'(en_cnt - en0), 1);
    check("t4_nob", 32'(warehouse_nob), 24);
    check("t4_err_count", 32'(err_cnt - err0), 1);
    check("t4_latency", 32'(err_cyc - en_cyc), 64);
    check("t4_err_code", 32'(err_code), 2);
    check("t4_busy_low", 32'(busy), 0);
    check("t4_x_kept", 32'(x_target), 210);

    // stop bit 0 drops the byte; receiver recovers for the next frame
    snap();
    send_byte(8'hAA, 1'b0);
    wait_cycles(40);
    check("bad_stop_busy", 32'(busy), 0);
    check("bad_stop_no_err", 32'(err_cnt - err0), 0);
    model_on = 1'b1; model_x = 9'd100; model_y = 8'd50;
    send_frame(8'hAA, 8'h02, 8'hA8);
    wait_cycles(150);
    check("recover_tv", 32'(tv_cnt - tv0), 1);
    check("recover_x", 32'(x_target), 100);
    check("recover_y", 32'(y_target), 50);

    // 5: gap timeout, then a normal frame
    snap();
    send_byte(8'hAA, 1'b1);
    wait_cycles(GAP + 50);
    check("t5_err_count", 32'(err_cnt - err0), 1);
    check("t5_err_code", 32'(err_code), 3);
    check("t5_busy_low", 32'(busy), 0);
    model_x = 9'd7; model_y = 8'd9;
    snap();
    send_frame(8'hAA, 8'h01, 8'hAB);
    wait_cycles(150);
    check("t5_next_tv", 32'(tv_cnt - tv0), 1);
    check("t5_next_nob", 32'(warehouse_nob), 1);
    check("t5_next_x", 32'(x_target), 7);
    check("t5_next_y", 32'(y_target), 9);

    // 6: reset while waiting for ready, then ready arrives
    model_x = 9'd300; model_y = 8'd200;
    snap();
    send_frame(8'hAA, 8'h03, 8'hA9);
    for (int i = 0; i < 200 && en_cnt == en0; i++) wait_cycles(1);
    check("t6_en_seen", 32'(en_cnt - en0), 1);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(100);
    check("t6_no_tv", 32'(tv_cnt - tv0), 0);
    check("t6_no_err", 32'(err_cnt - err0), 0);
    check("t6_x_zero", 32'(x_target), 0);
    check("t6_y_zero", 32'(y_target), 0);
    check("t6_nob_zero", 32'(warehouse_nob), 0);
    check("t6_busy_low", 32'(busy), 0);
    model_x = 9'd11; model_y = 8'd22;
    snap();
    send_frame(8'hAA, 8'h04, 8'hAE);
    wait_cycles(150);
    check("t6_next_tv", 32'(tv_cnt - tv0), 1);
    check("t6_next_x", 32'(x_target), 11);
    check("t6_next_y", 32'(y_target), 22);
    check("tv_ss_coincident", 32'(coinc_bad), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
